// File: rtl/axis_mac_tx_adapter.sv
// Store-and-forward adapter from a 32-bit AXI-Stream slave to the MAC transmit user interface.
// Optional frame/drop statistics outputs are compiled in with `define AXIS_TX_STATS_EN.
module axis_mac_tx_adapter #(
    parameter int AW        = 9,
    parameter int MIN_WORDS = 2
) (
    input  logic        Clk_user,
    input  logic        Reset,
    input  logic        S_AXIS_tvalid,
    output logic        S_AXIS_tready,
    input  logic [31:0] S_AXIS_tdata,
    input  logic [3:0]  S_AXIS_tstrb,
    input  logic        S_AXIS_tlast,
    input  logic        Tx_mac_wa,
    output logic        Tx_mac_wr,
    output logic [31:0] Tx_mac_data,
    output logic [1:0]  Tx_mac_BE,
    output logic        Tx_mac_sop,
    output logic        Tx_mac_eop
`ifdef AXIS_TX_STATS_EN
    ,
    output logic [31:0] Stat_tx_frames,
    output logic [15:0] Stat_tx_drops
`endif
);

    // Handshakes: an S_AXIS word transfers on a rising edge where tvalid && tready are both 1;
    // a MAC word is presented (Tx_mac_wr=1) on the edge after a SEND cycle in which Tx_mac_wa=1.
    localparam int          DEPTH    = 2**AW;
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] FILL_HI  = (AW+1)'(DEPTH - 2);
    localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] MIN_LEN  = (AW+1)'(MIN_WORDS);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_SEND = 1'b1;

    // Word layout: {sop, eop, be[1:0], data[31:0]}
    logic [35:0] mem [DEPTH];

    logic [1:0]  wstate, wstate_d;
    logic [0:0]  rstate;
    logic [AW:0] wr_ptr, wr_ptr_d;
    logic [AW:0] commit_ptr, commit_ptr_d;
    logic [AW:0] rd_ptr, rd_ptr_d;
    logic [AW:0] frame_cnt, frame_cnt_d;
    logic [AW:0] fill_after, frame_len;
    logic        s_accept, wr_en, commit, drop;
    logic        tready_d;
    logic [1:0]  be_in;
    logic [35:0] rd_word;
    logic        send, eop_sent;

    assign s_accept = S_AXIS_tvalid && S_AXIS_tready;

    always_comb begin
        case (S_AXIS_tstrb)
            4'b1000: be_in = 2'b01;
            4'b1100: be_in = 2'b10;
            4'b1110: be_in = 2'b11;
            default: be_in = 2'b00;
        endcase
    end

    // commit_ptr always marks the start of the frame being filled, so a rewind is a plain copy.
    always_comb begin
        wstate_d     = wstate;
        wr_ptr_d     = wr_ptr;
        commit_ptr_d = commit_ptr;
        wr_en        = 1'b0;
        commit       = 1'b0;
        drop         = 1'b0;
        fill_after   = wr_ptr + PTR_ONE - rd_ptr;
        frame_len    = wr_ptr - commit_ptr + PTR_ONE;
        if (s_accept) begin
            case (wstate)
                W_IDLE, W_FILL: begin
                    wr_en = 1'b1;
                    if (S_AXIS_tlast) begin
                        if (frame_len >= MIN_LEN) begin
                            commit       = 1'b1;
                            wr_ptr_d     = wr_ptr + PTR_ONE;
                            commit_ptr_d = wr_ptr + PTR_ONE;
                        end else begin
                            drop     = 1'b1;
                            wr_ptr_d = commit_ptr;
                        end
                        wstate_d = W_IDLE;
                    end else if (fill_after >= FILL_MAX) begin
                        drop     = 1'b1;
                        wr_ptr_d = commit_ptr;
                        wstate_d = W_DROP;
                    end else begin
                        wr_ptr_d = wr_ptr + PTR_ONE;
                        wstate_d = W_FILL;
                    end
                end
                W_DROP: begin
                    if (S_AXIS_tlast)
                        wstate_d = W_IDLE;
                end
                default: wstate_d = W_IDLE;
            endcase
        end
    end

    assign rd_word     = mem[rd_ptr[AW-1:0]];
    assign send        = (rstate == R_SEND) && Tx_mac_wa;
    assign eop_sent    = send && rd_word[34];
    assign rd_ptr_d    = send ? rd_ptr + PTR_ONE : rd_ptr;
    assign frame_cnt_d = frame_cnt + (commit ? PTR_ONE : '0) - (eop_sent ? PTR_ONE : '0);
    assign tready_d    = (wstate_d == W_DROP) || ((wr_ptr_d - rd_ptr_d) <= FILL_HI);

    always_ff @(posedge Clk_user) begin
        if (wr_en)
            mem[wr_ptr[AW-1:0]] <= {wstate == W_IDLE, S_AXIS_tlast, be_in, S_AXIS_tdata};
    end

    always_ff @(posedge Clk_user or posedge Reset) begin
        if (Reset) begin
            wstate        <= W_IDLE;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            rd_ptr        <= '0;
            frame_cnt     <= '0;
            S_AXIS_tready <= 1'b0;
        end else begin
            wstate        <= wstate_d;
            wr_ptr        <= wr_ptr_d;
            commit_ptr    <= commit_ptr_d;
            rd_ptr        <= rd_ptr_d;
            frame_cnt     <= frame_cnt_d;
            S_AXIS_tready <= tready_d;
        end
    end

    always_ff @(posedge Clk_user or posedge Reset) begin
        if (Reset) begin
            rstate      <= R_IDLE;
            Tx_mac_wr   <= 1'b0;
            Tx_mac_data <= '0;
            Tx_mac_BE   <= '0;
            Tx_mac_sop  <= 1'b0;
            Tx_mac_eop  <= 1'b0;
        end else begin
            Tx_mac_wr <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (frame_cnt != '0 && Tx_mac_wa)
                        rstate <= R_SEND;
                end
                R_SEND: begin
                    if (Tx_mac_wa) begin
                        Tx_mac_wr   <= 1'b1;
                        Tx_mac_data <= rd_word[31:0];
                        Tx_mac_BE   <= rd_word[34] ? rd_word[33:32] : 2'b00;
                        Tx_mac_sop  <= rd_word[35];
                        Tx_mac_eop  <= rd_word[34];
                        if (rd_word[34])
                            rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

`ifdef AXIS_TX_STATS_EN
    always_ff @(posedge Clk_user or posedge Reset) begin
        if (Reset) begin
            Stat_tx_frames <= '0;
            Stat_tx_drops  <= '0;
        end else begin
            if (commit && Stat_tx_frames != 32'hFFFF_FFFF)
                Stat_tx_frames <= Stat_tx_frames + 32'd1;
            if (drop && Stat_tx_drops != 16'hFFFF)
                Stat_tx_drops <= Stat_tx_drops + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_mac_tx_adapter.sv
// Self-checking bench for axis_mac_tx_adapter: table-driven frames, directed corner sequences and
// randomized frames against a frame-level reference model. Stats are checked when AXIS_TX_STATS_EN is defined.
module tb_axis_mac_tx_adapter;

    localparam int AW        = 9;
    localparam int MIN_WORDS = 2;
    localparam int DEPTH     = 2**AW;

    logic        Clk_user = 1'b0;
    logic        Reset = 1'b1;
    logic        S_AXIS_tvalid = 1'b0;
    logic        S_AXIS_tready;
    logic [31:0] S_AXIS_tdata = '0;
    logic [3:0]  S_AXIS_tstrb = '0;
    logic        S_AXIS_tlast = 1'b0;
    logic        Tx_mac_wa = 1'b0;
    logic        Tx_mac_wr;
    logic [31:0] Tx_mac_data;
    logic [1:0]  Tx_mac_BE;
    logic        Tx_mac_sop;
    logic        Tx_mac_eop;
`ifdef AXIS_TX_STATS_EN
    logic [31:0] Stat_tx_frames;
    logic [15:0] Stat_tx_drops;
`endif

    axis_mac_tx_adapter #(.AW(AW), .MIN_WORDS(MIN_WORDS)) dut (
        .Clk_user      (Clk_user),
        .Reset         (Reset),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tready (S_AXIS_tready),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tstrb  (S_AXIS_tstrb),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .Tx_mac_wa     (Tx_mac_wa),
        .Tx_mac_wr     (Tx_mac_wr),
        .Tx_mac_data   (Tx_mac_data),
        .Tx_mac_BE     (Tx_mac_BE),
        .Tx_mac_sop    (Tx_mac_sop),
        .Tx_mac_eop    (Tx_mac_eop)
`ifdef AXIS_TX_STATS_EN
        ,
        .Stat_tx_frames(Stat_tx_frames),
        .Stat_tx_drops (Stat_tx_drops)
`endif
    );

    // ---------------- clock / cycle counter ----------------
    always #5 Clk_user = ~Clk_user;

    int cyc = 0;
    always @(posedge Clk_user) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [35:0] exp_q[$];
    int          n_words = 0;
    int          sop_cyc = 0;
    int          acc_cyc = 0;
    int          stalls = 0;
    int          gap_max = 0;
    int          frame_id = 0;
    int          exp_frames = 0;
    int          exp_drops = 0;
    bit          mon_off = 1'b0;
    int          wa_mode = 0;
    int          wa_phase = 0;
    logic        wa_prev = 1'b0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endfunction

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    // ---------------- reference model (frame level) ----------------
    function automatic logic [1:0] model_be(input logic [3:0] s);
        int bytes;
        if (s == 4'b1111 || s == 4'b1110 || s == 4'b1100 || s == 4'b1000)
            bytes = $countones(s);
        else
            bytes = 4;
        return 2'(bytes % 4);
    endfunction

    // Only valid when the buffer starts empty for the frame in question.
    function automatic bit model_kept(input int len);
        return (len >= MIN_WORDS) && (len <= DEPTH - 1);
    endfunction

    // ---------------- MAC-side ready driver ----------------
    initial begin
        forever begin
            @(negedge Clk_user);
            case (wa_mode)
                0: Tx_mac_wa = 1'b1;
                1: begin
                    Tx_mac_wa = ((wa_phase % 4) == 0) || ((wa_phase % 4) == 3);
                    wa_phase++;
                end
                2: Tx_mac_wa = ($urandom_range(0, 3) != 0);
                default: Tx_mac_wa = 1'b0;
            endcase
        end
    end

    always @(posedge Clk_user) wa_prev <= Tx_mac_wa;

    // ---------------- output monitor ----------------
    always @(negedge Clk_user) begin
        logic [35:0] got;
        if (!Reset && !mon_off && Tx_mac_wr) begin
            n_words++;
            got = {Tx_mac_sop, Tx_mac_eop, Tx_mac_BE, Tx_mac_data};
            if (Tx_mac_sop) sop_cyc = cyc;
            check("wr_needs_wa", 64'(wa_prev), 64'd1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got %0h, required no word", got);
            end else begin
                check("tx_word", 64'(got), 64'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- S_AXIS driver tasks ----------------
    task automatic drive_word(input logic [31:0] d, input logic [3:0] s, input logic l);
        int guard;
        guard = 0;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge Clk_user);
        @(negedge Clk_user);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = d;
        S_AXIS_tstrb  = s;
        S_AXIS_tlast  = l;
        while (S_AXIS_tready !== 1'b1 && guard < 5000) begin
            stalls++;
            guard++;
            @(negedge Clk_user);
        end
        if (guard >= 5000) begin
            n_vec++;
            n_err++;
            $display("FAIL tready_timeout: got tready=%b, required 1 within 5000 cycles", S_AXIS_tready);
            finish_run();
        end
        @(posedge Clk_user);
        #1;
        S_AXIS_tvalid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send_frame(input int len, input logic [3:0] last_strb, input bit keep, input logic [1:0] be);
        logic [31:0] d;
        logic [7:0]  fid;
        frame_id++;
        fid = 8'(frame_id);
        if (keep) exp_frames++; else exp_drops++;
        for (int i = 0; i < len; i++) begin
            d = {fid, 8'(i), 16'($urandom)};
            if (keep)
                exp_q.push_back({i == 0, i == len - 1, (i == len - 1) ? be : 2'b00, d});
            drive_word(d, (i == len - 1) ? last_strb : 4'b1111, i == len - 1);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge Clk_user);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (8) @(negedge Clk_user);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] strb;
        int         len;
        logic [1:0] be;
        bit         sent;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int w0;
        int lat;
        int len;
        logic [3:0] strb;
        logic [3:0] legal [4];

        tbl[0] = '{4'b1111, 16, 2'b00, 1'b1};  // 64-byte frame
        tbl[1] = '{4'b1000, 16, 2'b01, 1'b1};  // 61 bytes
        tbl[2] = '{4'b1100, 16, 2'b10, 1'b1};  // 62 bytes
        tbl[3] = '{4'b1110,  5, 2'b11, 1'b1};
        tbl[4] = '{4'b0101,  4, 2'b00, 1'b1};  // illegal strobe counts as 4 bytes
        tbl[5] = '{4'b1111,  1, 2'b00, 1'b0};  // short frame dropped
        tbl[6] = '{4'b1000,  2, 2'b01, 1'b1};  // minimum length right after a drop
        tbl[7] = '{4'b0000,  3, 2'b00, 1'b1};
        tbl[8] = '{4'b1110,  1, 2'b00, 1'b0};
        legal[0] = 4'b1111;
        legal[1] = 4'b1110;
        legal[2] = 4'b1100;
        legal[3] = 4'b1000;

        // reset state
        repeat (3) @(negedge Clk_user);
        check("reset_outputs",
              64'({S_AXIS_tready, Tx_mac_wr, Tx_mac_data, Tx_mac_BE, Tx_mac_sop, Tx_mac_eop}), 64'd0);
`ifdef AXIS_TX_STATS_EN
        check("reset_stats", 64'({Stat_tx_frames, Stat_tx_drops}), 64'd0);
`endif
        Reset = 1'b0;
        @(negedge Clk_user);
        check("tready_after_reset", 64'(S_AXIS_tready), 64'd1);

        // table-driven frames, MAC always ready
        wa_mode = 0;
        for (int i = 0; i < 9; i++) begin
            w0 = n_words;
            send_frame(tbl[i].len, tbl[i].strb, tbl[i].sent, tbl[i].be);
            wait_drain(300);
            check("tbl_word_count", 64'(n_words - w0), 64'(tbl[i].sent ? tbl[i].len : 0));
        end

        // first word no earlier than 2 cycles after tlast acceptance
        send_frame(4, 4'b1111, 1'b1, 2'b00);
        wait_drain(100);
        lat = sop_cyc - acc_cyc;
        check("latency_ge_2", 64'(lat >= 2), 64'd1);

        // oversize frame then a normal one; tready must never stall
        stalls = 0;
        w0 = n_words;
        send_frame(600, 4'b1111, model_kept(600), 2'b00);
        check("ovf_no_stall", 64'(stalls), 64'd0);
        send_frame(20, 4'b1111, model_kept(20), 2'b00);
        wait_drain(500);
        check("ovf_word_count", 64'(n_words - w0), 64'd20);

        // back-to-back 8-word frames with Tx_mac_wa pattern 1,0,0,1
        wa_phase = 0;
        wa_mode = 1;
        w0 = n_words;
        for (int f = 0; f < 4; f++) send_frame(8, 4'b1111, 1'b1, 2'b00);
        wait_drain(500);
        check("toggle_word_count", 64'(n_words - w0), 64'd32);
        check("toggle_frame_cnt_zero", 64'(dut.frame_cnt), 64'd0);

        // randomized frames, random gaps and MAC readiness
        wa_mode = 2;
        gap_max = 2;
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 16);
            if ($urandom_range(0, 5) < 4) strb = legal[$urandom_range(0, 3)];
            else strb = 4'($urandom);
            send_frame(len, strb, model_kept(len), model_be(strb));
        end
        gap_max = 0;
        wait_drain(3000);
        check("rand_frame_cnt_zero", 64'(dut.frame_cnt), 64'd0);
`ifdef AXIS_TX_STATS_EN
        check("stat_frames", 64'(Stat_tx_frames), 64'(exp_frames));
        check("stat_drops", 64'(Stat_tx_drops), 64'(exp_drops));
`endif

        // reset with a frame being read and another being written
        mon_off = 1'b1;
        wa_mode = 3;
        repeat (2) @(negedge Clk_user);
        send_frame(20, 4'b1111, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++) drive_word(32'hA5A5_0000 + 32'(i), 4'b1111, 1'b0);
        wa_mode = 0;
        repeat (5) @(negedge Clk_user);
        Reset = 1'b1;
        #1;
        check("midframe_reset_outputs",
              64'({S_AXIS_tready, Tx_mac_wr, Tx_mac_data, Tx_mac_BE, Tx_mac_sop, Tx_mac_eop}), 64'd0);
`ifdef AXIS_TX_STATS_EN
        check("midframe_reset_stats", 64'({Stat_tx_frames, Stat_tx_drops}), 64'd0);
`endif
        exp_q.delete();
        exp_frames = 0;
        exp_drops = 0;
        repeat (2) @(negedge Clk_user);
        Reset = 1'b0;
        mon_off = 1'b0;
        w0 = n_words;
        send_frame(4, 4'b1100, 1'b1, 2'b10);
        wait_drain(100);
        check("post_reset_word_count", 64'(n_words - w0), 64'd4);
        check("post_reset_frame_cnt", 64'(dut.frame_cnt), 64'd0);
`ifdef AXIS_TX_STATS_EN
        check("post_reset_stat_frames", 64'(Stat_tx_frames), 64'(exp_frames));
`endif

        finish_run();
    end

    initial begin
        #800000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got no completion, required finish before 80000 cycles");
        finish_run();
    end

endmodule
